// File: rtl/memory_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// memory_bus_arbiter_if
//   Bundles the core-side request/response signals and the memory-side strobe
//   signals of the instruction/data memory arbiter.
//   Modports:
//     slave  - arbiter view: core requests and memory replies in; core
//              responses and memory strobes out.
//     master - environment view (core + memory): the opposite directions.
//   Signals:
//     instruction_request/address      fetch request and PC
//     instruction_response/data        fetch completion pulse and fetched word
//     data_memory_read/write           load/store request levels
//     data_address, write_data         load/store address and store data
//     data_memory_response, read_data  load/store completion pulse and result
//     mem_read/mem_write               memory strobes, held until mem_response
//     mem_address, mem_write_data      memory address and store data
//     mem_read_data, mem_response      memory read data and completion pulse
// ----------------------------------------------------------------------------
interface memory_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  instruction_request;
    logic [ADDR_WIDTH-1:0] instruction_address;
    logic                  instruction_response;
    logic [DATA_WIDTH-1:0] instruction_data;
    logic                  data_memory_read;
    logic                  data_memory_write;
    logic [ADDR_WIDTH-1:0] data_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  data_memory_response;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_response;

    modport slave (
        input  instruction_request, instruction_address,
        input  data_memory_read, data_memory_write, data_address, write_data,
        input  mem_read_data, mem_response,
        output instruction_response, instruction_data,
        output data_memory_response, read_data,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output instruction_request, instruction_address,
        output data_memory_read, data_memory_write, data_address, write_data,
        output mem_read_data, mem_response,
        input  instruction_response, instruction_data,
        input  data_memory_response, read_data,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// ----------------------------------------------------------------------------
// memory_bus_arbiter
//   Shares one single-port memory between the instruction and data buses of
//   the core, with at most one transaction outstanding. Data requests win,
//   but after MAX_DATA_GRANTS consecutive data grants with a fetch waiting the
//   fetch is served (MAX_DATA_GRANTS = 0 gives strict data priority). A fetch
//   whose PC has moved by the time memory answers is dropped silently.
//   Ports:
//     clk     - clock, rising edge
//     reset   - asynchronous active-low reset
//     io_bus  - core and memory signals (memory_bus_arbiter_if.slave)
// ----------------------------------------------------------------------------
module memory_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_DATA_GRANTS = 4
) (
    input logic                  clk,
    input logic                  reset,
    memory_bus_arbiter_if.slave  io_bus
);

    localparam int unsigned CntW = (MAX_DATA_GRANTS > 0) ? $clog2(MAX_DATA_GRANTS + 1) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_DATA_GRANTS);

    typedef enum logic [2:0] {
        StIdle,
        StIbus,
        StDbus,
        StIdone,
        StDdone
    } state_e;

    state_e                r_state;
    logic [CntW-1:0]       r_grant_cnt;
    logic                  r_op_write;
    logic                  r_instruction_response;
    logic [DATA_WIDTH-1:0] r_instruction_data;
    logic                  r_data_memory_response;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_write_data;

    logic w_fetch_pend;
    logic w_data_pend;
    logic w_data_wins;

    assign w_fetch_pend = io_bus.instruction_request;
    assign w_data_pend  = io_bus.data_memory_read | io_bus.data_memory_write;
    // A waiting fetch only overrides data once the grant budget is spent.
    assign w_data_wins  = w_data_pend &&
                          ((MAX_DATA_GRANTS == 0) || (r_grant_cnt < MaxCnt) || !w_fetch_pend);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state                <= StIdle;
            r_grant_cnt            <= '0;
            r_op_write             <= 1'b0;
            r_instruction_response <= 1'b0;
            r_instruction_data     <= '0;
            r_data_memory_response <= 1'b0;
            r_read_data            <= '0;
            r_mem_read             <= 1'b0;
            r_mem_write            <= 1'b0;
            r_mem_address          <= '0;
            r_mem_write_data       <= '0;
        end else begin
            r_instruction_response <= 1'b0;
            r_data_memory_response <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_data_wins) begin
                        r_state          <= StDbus;
                        // Write takes precedence when both strobes are high.
                        r_op_write       <= io_bus.data_memory_write;
                        r_mem_write      <= io_bus.data_memory_write;
                        r_mem_read       <= !io_bus.data_memory_write;
                        r_mem_address    <= io_bus.data_address;
                        r_mem_write_data <= io_bus.write_data;
                        if (w_fetch_pend && (r_grant_cnt != MaxCnt)) begin
                            r_grant_cnt <= r_grant_cnt + 1'b1;
                        end
                    end else if (w_fetch_pend) begin
                        r_state       <= StIbus;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= io_bus.instruction_address;
                        r_grant_cnt   <= '0;
                    end
                end
                StIbus: begin
                    if (io_bus.mem_response) begin
                        r_state            <= StIdone;
                        r_mem_read         <= 1'b0;
                        r_instruction_data <= io_bus.mem_read_data;
                        // r_mem_address still holds the fetched PC; a moved PC marks it stale.
                        r_instruction_response <= (io_bus.instruction_address == r_mem_address);
                    end
                end
                StDbus: begin
                    if (io_bus.mem_response) begin
                        r_state                <= StDdone;
                        r_mem_read             <= 1'b0;
                        r_mem_write            <= 1'b0;
                        r_data_memory_response <= 1'b1;
                        if (!r_op_write) begin
                            r_read_data <= io_bus.mem_read_data;
                        end
                    end
                end
                StIdone, StDdone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.instruction_response = r_instruction_response;
    assign io_bus.instruction_data     = r_instruction_data;
    assign io_bus.data_memory_response = r_data_memory_response;
    assign io_bus.read_data            = r_read_data;
    assign io_bus.mem_read             = r_mem_read;
    assign io_bus.mem_write            = r_mem_write;
    assign io_bus.mem_address          = r_mem_address;
    assign io_bus.mem_write_data       = r_mem_write_data;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memory_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    memory_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    memory_bus_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_DATA_GRANTS (2)
    ) u_dut (
        .clk    (clk),
        .reset  (rst_n),
        .io_bus (bus_a.slave)
    );

    memory_bus_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_DATA_GRANTS (0)
    ) u_dut0 (
        .clk    (clk),
        .reset  (rst_n),
        .io_bus (bus_b.slave)
    );

    // Memory contents: 0x100 holds 0x33, elsewhere {addr[15:0], ~addr[15:0]}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0033;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model A: waits_a wait cycles, plus a forced stray response.
    int unsigned waits_a;
    int unsigned wcnt_a;
    logic        force_resp_a;
    assign bus_a.mem_response  = ((bus_a.mem_read | bus_a.mem_write) && (wcnt_a == waits_a))
                                 || force_resp_a;
    assign bus_a.mem_read_data = mem_word(bus_a.mem_address);
    always @(posedge clk) begin
        if (!(bus_a.mem_read | bus_a.mem_write) || bus_a.mem_response) wcnt_a <= 0;
        else wcnt_a <= wcnt_a + 1;
    end

    // Memory model B: always zero-wait.
    assign bus_b.mem_response  = bus_b.mem_read | bus_b.mem_write;
    assign bus_b.mem_read_data = mem_word(bus_b.mem_address);

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // op: 0 fetch, 1 load, 2 store, 3 read+write together (acts as store)
    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned waits;
        logic [31:0] exp_data;
        int          exp_strobes;
    } vec_t;

    task automatic run_txn(input vec_t v, input string tag);
        int          strobe_cnt;
        int          lat;
        logic        bad;
        logic        got;
        logic        bus_ok;
        logic [31:0] data;
        strobe_cnt = 0; lat = 0; bad = 1'b0; got = 1'b0; bus_ok = 1'b1; data = '0;
        waits_a = v.waits;
        if (v.op == 0) begin
            bus_a.instruction_address = v.addr;
            bus_a.instruction_request = 1'b1;
        end else begin
            bus_a.data_address      = v.addr;
            bus_a.write_data        = v.wdata;
            bus_a.data_memory_read  = (v.op == 1) || (v.op == 3);
            bus_a.data_memory_write = (v.op >= 2);
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (v.op <= 1) begin
                if (bus_a.mem_write) bad = 1'b1;
                if (bus_a.mem_read) begin
                    strobe_cnt++;
                    if (bus_a.mem_address !== v.addr) bus_ok = 1'b0;
                end
            end else begin
                if (bus_a.mem_read) bad = 1'b1;
                if (bus_a.mem_write) begin
                    strobe_cnt++;
                    if (bus_a.mem_address !== v.addr || bus_a.mem_write_data !== v.wdata)
                        bus_ok = 1'b0;
                end
            end
            if (v.op == 0) begin
                if (bus_a.data_memory_response) bad = 1'b1;
                if (bus_a.instruction_response) begin
                    got = 1'b1; lat = c; data = bus_a.instruction_data;
                end
            end else begin
                if (bus_a.instruction_response) bad = 1'b1;
                if (bus_a.data_memory_response) begin
                    got = 1'b1; lat = c; data = bus_a.read_data;
                end
            end
            if (got) break;
        end
        bus_a.instruction_request = 1'b0;
        bus_a.data_memory_read    = 1'b0;
        bus_a.data_memory_write   = 1'b0;
        chk({tag, " response seen"}, 32'(got), 32'd1);
        chk({tag, " data"}, data, v.exp_data);
        chk({tag, " latency"}, 32'(lat), 32'(2 + v.waits));
        chk({tag, " strobe cycles"}, 32'(strobe_cnt), 32'(v.exp_strobes));
        chk({tag, " bus addr/wdata"}, 32'(bus_ok), 32'd1);
        chk({tag, " no wrong strobe/resp"}, 32'(bad), 32'd0);
        @(posedge clk); #1;
        chk({tag, " pulse one cycle"},
            32'(bus_a.instruction_response | bus_a.data_memory_response), 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        logic [5:0]  order;
        int          n_ev;
        int          n_i;
        int          n_d;
        logic        seen;
        logic [31:0] dval;
        logic [31:0] ival;

        n_pass = 0;
        n_total = 0;
        waits_a = 0;
        force_resp_a = 1'b0;
        rst_n = 1'b0;
        bus_a.instruction_request = 1'b0; bus_a.instruction_address = '0;
        bus_a.data_memory_read = 1'b0; bus_a.data_memory_write = 1'b0;
        bus_a.data_address = '0; bus_a.write_data = '0;
        bus_b.instruction_request = 1'b0; bus_b.instruction_address = '0;
        bus_b.data_memory_read = 1'b0; bus_b.data_memory_write = 1'b0;
        bus_b.data_address = '0; bus_b.write_data = '0;

        vecs[0] = '{op: 0, addr: 32'h100,  wdata: '0,           waits: 0,
                    exp_data: 32'h0000_0033, exp_strobes: 1};
        vecs[1] = '{op: 1, addr: 32'h8000, wdata: '0,           waits: 0,
                    exp_data: 32'h8000_7FFF, exp_strobes: 1};
        vecs[2] = '{op: 2, addr: 32'h8004, wdata: 32'hDEADBEEF, waits: 3,
                    exp_data: 32'h8000_7FFF, exp_strobes: 4};
        vecs[3] = '{op: 1, addr: 32'h1234, wdata: '0,           waits: 1,
                    exp_data: 32'h1234_EDCB, exp_strobes: 2};
        vecs[4] = '{op: 0, addr: 32'h2000, wdata: '0,           waits: 2,
                    exp_data: 32'h2000_DFFF, exp_strobes: 3};
        vecs[5] = '{op: 3, addr: 32'h40,   wdata: 32'h11223344, waits: 0,
                    exp_data: 32'h1234_EDCB, exp_strobes: 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_read", 32'(bus_a.mem_read), 32'd0);
        chk("reset mem_write", 32'(bus_a.mem_write), 32'd0);
        chk("reset mem_address", bus_a.mem_address, 32'd0);
        chk("reset responses", 32'(bus_a.instruction_response | bus_a.data_memory_response), 32'd0);
        chk("reset read_data", bus_a.read_data, 32'd0);
        chk("reset instruction_data", bus_a.instruction_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single transactions from the vector table
        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous fetch and load: load first, then fetch
        waits_a = 0;
        bus_a.instruction_address = 32'h200; bus_a.instruction_request = 1'b1;
        bus_a.data_address = 32'h8000; bus_a.data_memory_read = 1'b1;
        order = '0; n_ev = 0; dval = '0; ival = '0;
        for (int c = 0; c < 30 && n_ev < 2; c++) begin
            @(posedge clk); #1;
            if (bus_a.data_memory_response) begin
                dval = bus_a.read_data; n_ev++; bus_a.data_memory_read = 1'b0;
            end
            if (bus_a.instruction_response) begin
                order[n_ev] = 1'b1; ival = bus_a.instruction_data; n_ev++;
                bus_a.instruction_request = 1'b0;
            end
        end
        bus_a.instruction_request = 1'b0; bus_a.data_memory_read = 1'b0;
        chk("prio event count", 32'(n_ev), 32'd2);
        chk("prio order D then I", 32'(order[1:0]), 32'b10);
        chk("prio load data", dval, 32'h8000_7FFF);
        chk("prio fetch data", ival, 32'h0200_FDFF);
        @(posedge clk); #1;

        // MAX_DATA_GRANTS=2: D,D,I,D,D,I under continuous load + fetch
        bus_a.instruction_address = 32'h20; bus_a.instruction_request = 1'b1;
        bus_a.data_address = 32'h10; bus_a.data_memory_read = 1'b1;
        order = '0; n_ev = 0;
        for (int c = 0; c < 100 && n_ev < 6; c++) begin
            @(posedge clk); #1;
            if (bus_a.instruction_response) begin order[n_ev] = 1'b1; n_ev++; end
            else if (bus_a.data_memory_response) n_ev++;
        end
        bus_a.instruction_request = 1'b0; bus_a.data_memory_read = 1'b0;
        chk("fair event count", 32'(n_ev), 32'd6);
        chk("fair order DDIDDI", 32'(order), 32'b100100);
        repeat (3) @(posedge clk);
        #1;

        // MAX_DATA_GRANTS=0: fetch starves while a load is pending
        bus_b.instruction_address = 32'h20; bus_b.instruction_request = 1'b1;
        bus_b.data_address = 32'h10; bus_b.data_memory_read = 1'b1;
        n_i = 0; n_d = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (bus_b.instruction_response) n_i++;
            if (bus_b.data_memory_response) n_d++;
        end
        bus_b.data_memory_read = 1'b0;
        chk("strict no fetch", 32'(n_i), 32'd0);
        chk("strict loads served", 32'(n_d > 10), 32'd1);
        seen = 1'b0; ival = '0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus_b.instruction_response) begin seen = 1'b1; ival = bus_b.instruction_data; end
        end
        bus_b.instruction_request = 1'b0;
        chk("strict fetch after release", 32'(seen), 32'd1);
        chk("strict fetch data", ival, 32'h0020_FFDF);

        // Stale fetch: PC moves while fetch 0x300 is in flight
        waits_a = 3;
        bus_a.instruction_address = 32'h300; bus_a.instruction_request = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus_a.mem_read) begin seen = 1'b1; dval = bus_a.mem_address; end
        end
        chk("stale first grant", 32'(seen), 32'd1);
        chk("stale first addr", dval, 32'h300);
        bus_a.instruction_address = 32'h400;
        n_i = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus_a.instruction_response) n_i++;
            if (bus_a.mem_read && bus_a.mem_address == 32'h400) seen = 1'b1;
        end
        chk("stale no response", 32'(n_i), 32'd0);
        chk("stale refetch 0x400", 32'(seen), 32'd1);
        chk("stale data still latched", bus_a.instruction_data, 32'h0300_FCFF);
        seen = 1'b0; ival = '0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus_a.instruction_response) begin seen = 1'b1; ival = bus_a.instruction_data; end
        end
        bus_a.instruction_request = 1'b0;
        chk("refetch response", 32'(seen), 32'd1);
        chk("refetch data", ival, 32'h0400_FBFF);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a load
        waits_a = 5;
        bus_a.data_address = 32'h8000; bus_a.data_memory_read = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus_a.mem_read) seen = 1'b1;
        end
        chk("areset load granted", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset mem_read", 32'(bus_a.mem_read), 32'd0);
        chk("areset mem_address", bus_a.mem_address, 32'd0);
        chk("areset read_data", bus_a.read_data, 32'd0);
        bus_a.data_memory_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        force_resp_a = 1'b1;
        @(posedge clk); #1;
        force_resp_a = 1'b0;
        n_ev = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus_a.instruction_response | bus_a.data_memory_response |
                bus_a.mem_read | bus_a.mem_write) n_ev++;
        end
        chk("stray mem_response ignored", 32'(n_ev), 32'd0);
        vecs[3].waits = 0;
        vecs[3].exp_strobes = 1;
        run_txn(vecs[3], "post-reset load");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
